// File: rtl/clk_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_mon_pkg
//  Description : Shared types and default constants for the clock period
//                monitor: FSM state encoding, default counter width and
//                default lock threshold.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_mon_pkg;

    // Monitor FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,   // waiting for the first rising edge
        ST_MEASURE = 2'd1,   // first rise seen, timing the first full period
        ST_TRACK   = 2'd2,   // reference held, counting equal periods
        ST_LOCKED  = 2'd3    // LOCK_CNT consecutive equal periods observed
    } state_t;

    localparam int c_DEF_CNT_W    = 8;
    localparam int c_DEF_LOCK_CNT = 4;

endpackage : clk_mon_pkg
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : edge_sync
//  Description : Two-flop synchronizer for an asynchronous input, followed by
//                registered one-cycle rise and fall detectors. From an input
//                edge to the detect pulse is 3 clock cycles.
//  Ports       : clk      - clock
//                rst      - synchronous active-high reset
//                i_async  - asynchronous input
//                o_rise   - one-cycle pulse on a synchronized 0->1 transition
//                o_fall   - one-cycle pulse on a synchronized 1->0 transition
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;   // first synchronizer stage, may go metastable
    logic r_sync;   // second synchronizer stage, safe to use
    logic r_prev;   // previous synchronized value for edge detection

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            o_rise <= r_sync & ~r_prev;
            o_fall <= ~r_sync & r_prev;
        end
    end

endmodule : edge_sync
`default_nettype wire

// File: rtl/clk_period_mon.sv
`default_nettype none
// ============================================================================
//  Module      : clk_period_mon
//  Description : Measures the period and high time of a slow (divided) clock
//                in units of clkin cycles, tracks period stability and flags
//                lock, period changes and missing edges.
//  Ports       : clkin        - single clock, all logic on its rising edge
//                rst          - synchronous active-high reset
//                slow_in      - clock under test, asynchronous to clkin
//                period       - last measured rise-to-rise interval
//                high_time    - cycles slow_in was high in that interval
//                period_valid - one-cycle pulse when period/high_time update
//                locked       - period stable for LOCK_CNT measurements
//                mismatch     - one-cycle pulse on a period change
//                timeout      - one-cycle pulse when the period counter
//                               saturates without a rising edge
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_period_mon
    import clk_mon_pkg::*;
#(
    parameter int CNT_W    = c_DEF_CNT_W,
    parameter int LOCK_CNT = c_DEF_LOCK_CNT
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             slow_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             mismatch,
    output logic             timeout
);

    localparam int               c_MATCH_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic                 w_rise;
    logic                 w_fall;
    logic                 w_hi_now;
    logic [c_MATCH_W-1:0] w_match_inc;

    state_t               r_state;
    logic                 r_hi;
    logic [CNT_W-1:0]     r_per_cnt;
    logic [CNT_W-1:0]     r_high_cnt;
    logic [CNT_W-1:0]     r_ref;
    logic [c_MATCH_W-1:0] r_match;

    edge_sync u_edge_sync (
        .clk     (clkin),
        .rst     (rst),
        .i_async (slow_in),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Synchronized level, rebuilt from the edge pulses so it lines up with
    // them: it is already 1 in the rise cycle and already 0 in the fall cycle.
    assign w_hi_now    = w_rise | (r_hi & ~w_fall);
    assign w_match_inc = r_match + 1'b1;

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_hi         <= 1'b0;
            r_per_cnt    <= '0;
            r_high_cnt   <= '0;
            r_ref        <= '0;
            r_match      <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            mismatch     <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            mismatch     <= 1'b0;
            timeout      <= 1'b0;
            r_hi         <= w_hi_now;

            case (r_state)
                ST_IDLE: begin
                    r_per_cnt  <= '0;
                    r_high_cnt <= '0;
                    if (w_rise) begin
                        // The rise cycle is the first cycle of the new period
                        // and is high, so both counters restart at 1.
                        r_per_cnt  <= CNT_W'(1);
                        r_high_cnt <= CNT_W'(1);
                        r_state    <= ST_MEASURE;
                    end
                end

                default: begin
                    if (w_rise) begin
                        period       <= r_per_cnt;
                        high_time    <= r_high_cnt;
                        period_valid <= 1'b1;
                        r_per_cnt    <= CNT_W'(1);
                        r_high_cnt   <= CNT_W'(1);

                        case (r_state)
                            ST_MEASURE: begin
                                r_ref   <= r_per_cnt;
                                r_match <= c_MATCH_W'(1);
                                if (LOCK_CNT <= 1) begin
                                    r_state <= ST_LOCKED;
                                    locked  <= 1'b1;
                                end else begin
                                    r_state <= ST_TRACK;
                                end
                            end

                            ST_TRACK: begin
                                if (r_per_cnt == r_ref) begin
                                    r_match <= w_match_inc;
                                    if (w_match_inc == c_MATCH_W'(LOCK_CNT)) begin
                                        r_state <= ST_LOCKED;
                                        locked  <= 1'b1;
                                    end
                                end else begin
                                    mismatch <= 1'b1;
                                    r_ref    <= r_per_cnt;
                                    r_match  <= c_MATCH_W'(1);
                                end
                            end

                            ST_LOCKED: begin
                                if (r_per_cnt != r_ref) begin
                                    mismatch <= 1'b1;
                                    locked   <= 1'b0;
                                    r_ref    <= r_per_cnt;
                                    r_match  <= c_MATCH_W'(1);
                                    r_state  <= ST_TRACK;
                                end
                            end

                            default: ;
                        endcase
                    end else if (r_per_cnt == c_CNT_MAX) begin
                        // No edge within the measurable range: give up and
                        // wait for a fresh first rise.
                        timeout    <= 1'b1;
                        locked     <= 1'b0;
                        r_state    <= ST_IDLE;
                        r_per_cnt  <= '0;
                        r_high_cnt <= '0;
                    end else begin
                        r_per_cnt <= r_per_cnt + 1'b1;
                        if (w_hi_now) begin
                            r_high_cnt <= r_high_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule : clk_period_mon
`default_nettype wire

// File: tb/tb_clk_period_mon.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_period_mon
//  Description : Self-checking bench for clk_period_mon. Table rows drive
//                runs of identical slow_in periods; a behavioural model
//                pushes the expected measurement for every driven rise into a
//                scoreboard queue that a monitor pops on each period_valid.
//                Timeout and reset are exercised by hand-written sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_period_mon;

    localparam int c_CNT_W    = 8;
    localparam int c_LOCK_CNT = 4;
    localparam int c_SAT      = (1 << c_CNT_W) - 1;

    logic               clkin;
    logic               rst;
    logic               slow_in;
    logic [c_CNT_W-1:0] period;
    logic [c_CNT_W-1:0] high_time;
    logic               period_valid;
    logic               locked;
    logic               mismatch;
    logic               timeout;

    clk_period_mon #(
        .CNT_W    (c_CNT_W),
        .LOCK_CNT (c_LOCK_CNT)
    ) dut (
        .clkin        (clkin),
        .rst          (rst),
        .slow_in      (slow_in),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .locked       (locked),
        .mismatch     (mismatch),
        .timeout      (timeout)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    int cyc = 0;
    always @(posedge clkin) cyc++;

    typedef struct {
        int period;
        int high;
        bit lck;
        bit mis;
    } exp_t;

    typedef struct {
        int hi;
        int lo;
        int reps;
        int exp_period;
        int exp_high;
        bit exp_locked;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];

    int checks      = 0;
    int failures    = 0;
    int tb_timeouts = 0;

    // Reference model state: 0 idle, 1 measure, 2 track, 3 locked
    int m_state     = 0;
    int m_ref       = 0;
    int m_match     = 0;
    int m_last_rise = 0;
    int m_last_hi   = 0;
    int m_exp_to    = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    // Called at the cycle a rise is driven; hi is the high length of the
    // period that this rise starts.
    task automatic model_rise(input int hi);
        int   p;
        exp_t e;
        p = cyc - m_last_rise;
        if (m_state != 0 && p > c_SAT) begin
            m_state = 0;
            m_exp_to++;
        end
        e.period = p;
        e.high   = m_last_hi;
        e.mis    = 1'b0;
        case (m_state)
            0: m_state = 1;
            1: begin
                m_ref   = p;
                m_match = 1;
                m_state = (c_LOCK_CNT <= 1) ? 3 : 2;
                e.lck   = (m_state == 3);
                sb.push_back(e);
            end
            2: begin
                if (p == m_ref) begin
                    m_match++;
                    if (m_match == c_LOCK_CNT) m_state = 3;
                end else begin
                    e.mis   = 1'b1;
                    m_ref   = p;
                    m_match = 1;
                end
                e.lck = (m_state == 3);
                sb.push_back(e);
            end
            default: begin
                if (p != m_ref) begin
                    e.mis   = 1'b1;
                    m_ref   = p;
                    m_match = 1;
                    m_state = 2;
                end
                e.lck = (m_state == 3);
                sb.push_back(e);
            end
        endcase
        m_last_rise = cyc;
        m_last_hi   = hi;
    endtask

    task automatic drive_period(input int hi, input int lo);
        model_rise(hi);
        slow_in = 1'b1;
        repeat (hi) tick();
        slow_in = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic apply_row(input int idx);
        for (int r = 0; r < vecs[idx].reps; r++) begin
            drive_period(vecs[idx].hi, vecs[idx].lo);
        end
        check($sformatf("row%0d_period", idx), period, vecs[idx].exp_period);
        check($sformatf("row%0d_high_time", idx), high_time, vecs[idx].exp_high);
        check($sformatf("row%0d_locked", idx), locked, vecs[idx].exp_locked);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"}, period, 0);
        check({tag, "_high_time"}, high_time, 0);
        check({tag, "_period_valid"}, period_valid, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_mismatch"}, mismatch, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge clkin) begin
        if (!rst) begin
            if (timeout) begin
                tb_timeouts++;
                check("timeout_locked", locked, 0);
            end
            if (mismatch) begin
                check("mismatch_with_valid", period_valid, 1);
            end
            if (period_valid) begin
                if (sb.size() == 0) begin
                    check("pending_expectations", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_period", period, e.period);
                    check("sb_high_time", high_time, e.high);
                    check("sb_locked", locked, e.lck);
                    check("sb_mismatch", mismatch, e.mis);
                end
            end
        end
    end

    initial begin
        int t0;

        //                hi lo reps period high locked
        vecs[0] = '{6, 6, 8, 12, 6, 1'b1};   // divide-by-12, 50% duty
        vecs[1] = '{5, 5, 6, 10, 5, 1'b1};   // switch to period 10
        vecs[2] = '{3, 9, 8, 12, 3, 1'b1};   // 25% duty
        vecs[3] = '{1, 1, 8,  2, 1, 1'b1};   // minimum period
        vecs[4] = '{6, 6, 6, 12, 6, 1'b1};   // relock before timeout test
        vecs[5] = '{6, 6, 6, 12, 6, 1'b1};   // recovery after timeout
        vecs[6] = '{6, 6, 6, 12, 6, 1'b1};   // recovery after reset

        rst     = 1'b1;
        slow_in = 1'b0;
        repeat (3) @(posedge clkin);
        @(negedge clkin);
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            apply_row(i);
        end

        // Missing edges while locked
        t0 = tb_timeouts;
        drive_period(6, 300);
        check("timeout_pulses", tb_timeouts - t0, 1);
        check("timeout_unlocked", locked, 0);
        apply_row(5);
        check("timeout_model_count", tb_timeouts, m_exp_to);

        // Reset in the low phase of a period while locked
        drive_period(6, 0);
        slow_in = 1'b0;
        repeat (2) tick();
        t0 = tb_timeouts;
        rst = 1'b1;
        @(posedge clkin);
        @(negedge clkin);
        check_all_zero("midreset1");
        @(posedge clkin);
        @(negedge clkin);
        check_all_zero("midreset2");
        rst = 1'b0;
        tick();
        sb.delete();
        m_state = 0;
        repeat (3) tick();
        apply_row(6);
        check("reset_no_timeout", tb_timeouts, t0);

        repeat (8) tick();
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_clk_period_mon
`default_nettype wire

// File: doc/clk_period_mon.md
CLK_PERIOD_MON -- requirements
Module: clk_period_mon

Interface
REQ-001 Parameter CNT_W, default 8: width of period and high-time counters.
REQ-002 Parameter LOCK_CNT, default 4: consecutive equal periods required to assert locked.
REQ-003 clkin  input  1: single clock; all logic on its rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 slow_in  input  1: divided clock under test, e.g. divide-by-N output; treated as asynchronous data.
REQ-006 period  output  CNT_W: last measured rising-to-rising interval, in clkin cycles.
REQ-007 high_time  output  CNT_W: clkin cycles slow_in was high in the last period.
REQ-008 period_valid  output  1: one-cycle pulse when period/high_time update.
REQ-009 locked  output  1: level; period stable for LOCK_CNT consecutive measurements.
REQ-010 mismatch  output  1: one-cycle pulse when a period differs from the reference period while in TRACK or LOCKED.
REQ-011 timeout  output  1: one-cycle pulse when no edge arrives before the counter saturates.

Function
REQ-012 slow_in SHALL pass through a 2-flop synchronizer; rise and fall are detected on the synchronized signal, giving 3 clkin cycles of latency from the input edge to the detect pulse.
REQ-013 FSM states SHALL be IDLE, MEASURE, TRACK and LOCKED.
REQ-014 In IDLE, the first rise SHALL clear the counters and move to MEASURE; no period_valid is produced.
REQ-015 In MEASURE, the next rise SHALL latch the period counter (counting the rise cycle, so a 12-cycle period reads 12) as the reference, pulse period_valid, and move to TRACK with match count 1.
REQ-016 On a rise in TRACK, a period equal to the reference SHALL increment the match count; on reaching LOCK_CNT the FSM moves to LOCKED and locked is set in the same cycle.
REQ-017 On a rise in TRACK, an unequal period SHALL pulse mismatch, replace the reference and reset the match count to 1.
REQ-018 On a rise in LOCKED, an unequal period SHALL pulse mismatch, clear locked, replace the reference and move to TRACK with match count 1.
REQ-019 The high-time counter SHALL count while the synchronized slow_in is 1; it is latched into high_time at each rise, together with period, and then cleared.
REQ-020 The period counter SHALL saturate at 2^CNT_W-1; reaching saturation in MEASURE, TRACK or LOCKED SHALL pulse timeout, clear locked and move to IDLE.
REQ-021 A fall SHALL never change state; a period of 1 or 2 cycles (aliasing) is reported as measured.
REQ-022 period and high_time SHALL hold their values between period_valid pulses.

Reset
REQ-023 While rst=1 at a clkin edge, the FSM SHALL enter IDLE and the synchronizer flops, counters, reference and match count SHALL clear.
REQ-024 While rst=1, all outputs SHALL be 0.
REQ-025 Reset mid-measurement SHALL discard the partial period, and no pulse is emitted.
REQ-026 After rst is released, the first edge counted is a rise detected at least 3 cycles later.

Structure
REQ-027 Package clk_mon_pkg SHALL hold the state enum and the default CNT_W and LOCK_CNT constants.
REQ-028 Sub-module edge_sync SHALL contain the 2-flop synchronizer and the rise/fall one-cycle pulse detectors.
REQ-029 The FSM, counters and compare logic SHALL reside in clk_period_mon.

Verification
REQ-030 slow_in = divide-by-12, 6 high / 6 low, for 8 periods -> period=12 and high_time=6 on every pulse; locked rises at the 4th period_valid; no mismatch.
REQ-031 Locked at period 12, then switch to period 10 (5/5) -> mismatch pulse and locked=0 at the first 10; locked again after 4 periods of 10.
REQ-032 slow_in held 0 for 300 cycles after lock -> timeout pulse once, locked=0, FSM in IDLE; the next two rises produce one period_valid.
REQ-033 rst=1 for 2 cycles mid-period while locked -> all outputs 0; after release no pulse until a full period is measured.
REQ-034 Duty test: period 12 with 3 high / 9 low -> period=12, high_time=3; locked after 4 periods.
REQ-035 Minimum period: slow_in toggling every clkin cycle -> period=2, high_time=1; locked after 4 periods.
